// File: rtl/pulse_gen_pkg.sv
// Shared definitions for the multi-channel pulse generator.
package pulse_gen_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int DEFAULT_CNT_W = 32;

endpackage

// File: rtl/pulse_gen_chan.sv
// One pulse generator channel: latches its config on start, then emits
// periodic pulses until stopped or until the programmed burst completes.
module pulse_gen_chan
  import pulse_gen_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] width,
  input  logic [CNT_W-1:0] burst,
  output logic             pulse,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] npulse, npulse_nxt;
  logic [CNT_W-1:0] per_l, per_nxt;
  logic [CNT_W-1:0] wid_l, wid_nxt;
  logic [CNT_W-1:0] bst_l, bst_nxt;
  logic             pulse_nxt;
  logic             done_nxt;

  logic [CNT_W-1:0] per_eff;
  logic             last_cyc;
  logic             burst_end;

  // A zero period is treated as a one-cycle period.
  assign per_eff   = (per_l == '0) ? ONE : per_l;
  assign last_cyc  = (cnt == per_eff - ONE);
  assign burst_end = (bst_l != '0) && last_cyc && (npulse == bst_l - ONE);
  assign busy      = (state == ST_RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      npulse <= '0;
      per_l  <= '0;
      wid_l  <= '0;
      bst_l  <= '0;
      pulse  <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      npulse <= npulse_nxt;
      per_l  <= per_nxt;
      wid_l  <= wid_nxt;
      bst_l  <= bst_nxt;
      pulse  <= pulse_nxt;
      done   <= done_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    npulse_nxt = npulse;
    per_nxt    = per_l;
    wid_nxt    = wid_l;
    bst_nxt    = bst_l;
    pulse_nxt  = pulse;
    done_nxt   = 1'b0;

    unique case (state)
      ST_IDLE: begin
        pulse_nxt = 1'b0;
        if (start && !stop && en) begin
          state_nxt  = ST_RUN;
          per_nxt    = period;
          wid_nxt    = width;
          bst_nxt    = burst;
          cnt_nxt    = '0;
          npulse_nxt = '0;
          pulse_nxt  = (width != '0);
        end
      end

      ST_RUN: begin
        // Abort takes priority and ignores the enable.
        if (stop) begin
          state_nxt = ST_IDLE;
          pulse_nxt = 1'b0;
        end else if (en) begin
          if (last_cyc) begin
            cnt_nxt    = '0;
            npulse_nxt = npulse + ONE;
            pulse_nxt  = (wid_l != '0);
            if (burst_end) begin
              state_nxt = ST_IDLE;
              pulse_nxt = 1'b0;
              done_nxt  = 1'b1;
            end
          end else begin
            cnt_nxt   = cnt + ONE;
            pulse_nxt = ((cnt + ONE) < wid_l);
          end
        end
      end

      default: begin
        state_nxt = ST_IDLE;
        pulse_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/pulse_gen_multi.sv
// Multi-channel pulse generator: slices the packed config buses and
// instantiates one independent channel per lane.
module pulse_gen_multi
  import pulse_gen_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = DEFAULT_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       stop,
  input  logic [NUM_CH*CNT_W-1:0] period,
  input  logic [NUM_CH*CNT_W-1:0] width,
  input  logic [NUM_CH*CNT_W-1:0] burst,
  output logic [NUM_CH-1:0]       pulse,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       done
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    pulse_gen_chan #(
      .CNT_W (CNT_W)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .start  (start[i]),
      .stop   (stop[i]),
      .period (period[i*CNT_W +: CNT_W]),
      .width  (width[i*CNT_W +: CNT_W]),
      .burst  (burst[i*CNT_W +: CNT_W]),
      .pulse  (pulse[i]),
      .busy   (busy[i]),
      .done   (done[i])
    );
  end

endmodule

// File: tb/tb_pulse_gen_multi.sv
// Directed self-checking bench for pulse_gen_multi with hand-computed
// pulse/busy/done sequences per channel.
module tb_pulse_gen_multi;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 32;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    en;
  logic [NUM_CH-1:0]       start;
  logic [NUM_CH-1:0]       stop;
  logic [NUM_CH*CNT_W-1:0] period;
  logic [NUM_CH*CNT_W-1:0] width;
  logic [NUM_CH*CNT_W-1:0] burst;
  logic [NUM_CH-1:0]       pulse;
  logic [NUM_CH-1:0]       busy;
  logic [NUM_CH-1:0]       done;

  int n_checks = 0;
  int n_fails  = 0;

  pulse_gen_multi #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .start  (start),
    .stop   (stop),
    .period (period),
    .width  (width),
    .burst  (burst),
    .pulse  (pulse),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  // Advance past one rising edge; outputs are then stable for sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Load one channel's config and issue a single-edge start.
  task automatic applyStimulus(input int ch, input logic [CNT_W-1:0] per,
                               input logic [CNT_W-1:0] wid, input logic [CNT_W-1:0] bst);
    period[ch*CNT_W +: CNT_W] = per;
    width[ch*CNT_W +: CNT_W]  = wid;
    burst[ch*CNT_W +: CNT_W]  = bst;
    start[ch] = 1'b1;
    tick();
    start[ch] = 1'b0;
  endtask

  initial begin
    logic [9:0] exp_p1;
    logic [6:0] exp_p2;
    logic       exp_bit;

    rst    = 1'b1;
    en     = 1'b1;
    start  = '0;
    stop   = '0;
    period = '0;
    width  = '0;
    burst  = '0;

    tick();
    tick();
    checkOutput("reset_pulse", 32'(pulse), 32'h0);
    checkOutput("reset_busy",  32'(busy),  32'h0);
    checkOutput("reset_done",  32'(done),  32'h0);
    rst = 1'b0;
    tick();

    // Ch1 burst: period 5, width 3, 2 pulses -> HHHLL HHHLL then done.
    $display("[TB] ch1 burst");
    exp_p1 = 10'b0011100111;
    applyStimulus(1, 5, 3, 2);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) tick();
      checkOutput($sformatf("ch1_pulse_k%0d", k), 32'(pulse[1]), 32'(exp_p1[k]));
      checkOutput($sformatf("ch1_busy_k%0d", k),  32'(busy[1]),  32'h1);
      checkOutput($sformatf("ch1_done_k%0d", k),  32'(done[1]),  32'h0);
    end
    tick();
    checkOutput("ch1_done_end",  32'(done[1]),  32'h1);
    checkOutput("ch1_busy_end",  32'(busy[1]),  32'h0);
    checkOutput("ch1_pulse_end", 32'(pulse[1]), 32'h0);
    start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    checkOutput("ch1_restart_busy",  32'(busy[1]),  32'h1);
    checkOutput("ch1_restart_pulse", 32'(pulse[1]), 32'h1);
    checkOutput("ch1_restart_done",  32'(done[1]),  32'h0);
    stop[1] = 1'b1;
    tick();
    stop[1] = 1'b0;
    checkOutput("ch1_stop_busy", 32'(busy[1]), 32'h0);

    // Ch3: width exceeds period, second start ignored even with new period.
    $display("[TB] ch3 wide burst");
    applyStimulus(3, 4, 7, 3);
    for (int k = 0; k < 12; k++) begin
      if (k > 0) tick();
      checkOutput($sformatf("ch3_pulse_k%0d", k), 32'(pulse[3]), 32'h1);
      checkOutput($sformatf("ch3_busy_k%0d", k),  32'(busy[3]),  32'h1);
      checkOutput($sformatf("ch3_done_k%0d", k),  32'(done[3]),  32'h0);
      if (k == 1) begin
        start[3] = 1'b1;
        period[3*CNT_W +: CNT_W] = 2;
      end
      if (k == 2) start[3] = 1'b0;
    end
    tick();
    checkOutput("ch3_done_end",  32'(done[3]),  32'h1);
    checkOutput("ch3_busy_end",  32'(busy[3]),  32'h0);
    checkOutput("ch3_pulse_end", 32'(pulse[3]), 32'h0);
    tick();
    checkOutput("ch3_done_one_cycle", 32'(done[3]), 32'h0);

    // Ch2 continuous, stopped at t+7 while en is low; then start+stop together.
    $display("[TB] ch2 stop");
    exp_p2 = 7'b0001111;
    applyStimulus(2, 8, 4, 0);
    for (int k = 0; k < 7; k++) begin
      if (k > 0) tick();
      checkOutput($sformatf("ch2_pulse_k%0d", k), 32'(pulse[2]), 32'(exp_p2[k]));
      checkOutput($sformatf("ch2_busy_k%0d", k),  32'(busy[2]),  32'h1);
    end
    stop[2] = 1'b1;
    en      = 1'b0;
    tick();
    stop[2] = 1'b0;
    en      = 1'b1;
    checkOutput("ch2_stop_pulse", 32'(pulse[2]), 32'h0);
    checkOutput("ch2_stop_busy",  32'(busy[2]),  32'h0);
    checkOutput("ch2_stop_done",  32'(done[2]),  32'h0);
    start[2] = 1'b1;
    stop[2]  = 1'b1;
    tick();
    start[2] = 1'b0;
    stop[2]  = 1'b0;
    checkOutput("ch2_startstop_busy",  32'(busy[2]),  32'h0);
    checkOutput("ch2_startstop_pulse", 32'(pulse[2]), 32'h0);

    // Ch0 period 10 width 1, en low for 3 edges while the pulse is high.
    $display("[TB] ch0 enable stretch");
    applyStimulus(0, 10, 1, 0);
    checkOutput("ch0_pulse_k0", 32'(pulse[0]), 32'h1);
    for (int k = 1; k < 25; k++) begin
      tick();
      exp_bit = (k >= 10 && k <= 13) || (k == 23);
      checkOutput($sformatf("ch0_pulse_k%0d", k), 32'(pulse[0]), 32'(exp_bit));
      checkOutput($sformatf("ch0_busy_k%0d", k),  32'(busy[0]),  32'h1);
      checkOutput($sformatf("ch0_done_k%0d", k),  32'(done[0]),  32'h0);
      if (k == 10) en = 1'b0;
      if (k == 13) en = 1'b1;
    end
    stop[0] = 1'b1;
    tick();
    stop[0] = 1'b0;
    checkOutput("ch0_stop_busy", 32'(busy[0]), 32'h0);

    // All channels running, then asynchronous reset between edges.
    $display("[TB] async reset mid-burst");
    period = {32'd4, 32'd8, 32'd5, 32'd10};
    width  = {32'd7, 32'd4, 32'd3, 32'd1};
    burst  = {32'd3, 32'd3, 32'd2, 32'd5};
    start  = 4'hF;
    tick();
    start  = '0;
    tick();
    tick();
    checkOutput("all_busy_pre_rst",  32'(busy),  32'hF);
    checkOutput("all_pulse_pre_rst", 32'(pulse), 32'hE);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_pulse", 32'(pulse), 32'h0);
    checkOutput("async_rst_busy",  32'(busy),  32'h0);
    checkOutput("async_rst_done",  32'(done),  32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    applyStimulus(1, 5, 3, 2);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) tick();
      checkOutput($sformatf("post_rst_ch1_pulse_k%0d", k), 32'(pulse), 32'(exp_p1[k]) << 1);
      checkOutput($sformatf("post_rst_ch1_busy_k%0d", k),  32'(busy),  32'h2);
    end
    tick();
    checkOutput("post_rst_ch1_done", 32'(done), 32'h2);
    checkOutput("post_rst_ch1_busy_end", 32'(busy), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
